// File: rtl/npu_pkg.sv
// Shared widths, FSM encoding, ternary-weight decode and layer-config table for npu_conv_engine.
// Build option NPU_CKGATE_EN adds an active-lane count (ckg) to each layer entry.
package npu_pkg;
  localparam int N    = 8;
  localparam int W    = 8;
  localparam int ACCW = 12;
  localparam int KMAX = 3;
  localparam int AW   = 10;
  localparam int WAW  = 16;
  localparam int CW   = 4;  // holds K, B, C, T up to KMAX/4 and ckg up to W

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_MAC  = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  typedef struct packed {
    logic [CW-1:0] k;
    logic [CW-1:0] b;
    logic [CW-1:0] c;
    logic [CW-1:0] t;
`ifdef NPU_CKGATE_EN
    logic [CW-1:0] ckg;
`endif
  } layer_cfg_t;

  function automatic logic signed [1:0] w_decode(input logic [1:0] code);
    logic signed [1:0] v;
    case (code)
      2'b01:   v = 2'sb01;
      2'b11:   v = 2'sb11;
      default: v = 2'sb00;
    endcase
    return v;
  endfunction

  function automatic layer_cfg_t cfg_lookup(input logic sel_c1);
    layer_cfg_t cfg;
    if (sel_c1) begin
      cfg.k = 4'd3;
      cfg.b = 4'd1;
      cfg.c = 4'd4;
      cfg.t = 4'd4;
`ifdef NPU_CKGATE_EN
      cfg.ckg = 4'd8;
`endif
    end else begin
      cfg.k = 4'd3;
      cfg.b = 4'd4;
      cfg.c = 4'd4;
      cfg.t = 4'd2;
`ifdef NPU_CKGATE_EN
      cfg.ckg = 4'd6;
`endif
    end
    return cfg;
  endfunction
endpackage

// File: rtl/npu_mac_lane.sv
// One datapath lane: saturating signed multiply-accumulate of a ternary weight
// by a 4-bit activation, with a registered ReLU clamped to 0..15.
module npu_mac_lane
  import npu_pkg::*;
(
  input  logic              i_ck,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_mac,
  input  logic              i_wr,
  input  logic              i_lane_en,
  input  logic [3:0]        i_act,
  input  logic signed [1:0] i_w,
  output logic [N-1:0]      o_relu
);
  localparam logic signed [ACCW:0]   ACC_MAX  = {2'b00, {(ACCW-1){1'b1}}};
  localparam logic signed [ACCW:0]   ACC_MIN  = {2'b11, {(ACCW-2){1'b0}}, 1'b1};
  localparam logic signed [ACCW-1:0] RELU_MAX = {{(ACCW-4){1'b0}}, 4'hF};

  logic signed [ACCW-1:0] r_acc;
  logic [N-1:0]           r_relu;
  logic signed [ACCW:0]   w_term;
  logic signed [ACCW:0]   w_sum;
  logic signed [ACCW-1:0] w_acc_nxt;
  logic [N-1:0]           w_relu;

  // Next accumulator value, clamped symmetrically instead of wrapping.
  always_comb begin
    w_term = '0;
    case (i_w)
      2'sb01:  w_term = {{(ACCW-3){1'b0}}, i_act};
      2'sb11:  w_term = -{{(ACCW-3){1'b0}}, i_act};
      default: w_term = '0;
    endcase
    w_sum = $signed({r_acc[ACCW-1], r_acc}) + w_term;
    if (w_sum > ACC_MAX) begin
      w_acc_nxt = ACC_MAX[ACCW-1:0];
    end else if (w_sum < ACC_MIN) begin
      w_acc_nxt = ACC_MIN[ACCW-1:0];
    end else begin
      w_acc_nxt = w_sum[ACCW-1:0];
    end
  end

  // ReLU of the current accumulator, clamped to the 4-bit activation range.
  always_comb begin
    w_relu = '0;
    if (r_acc[ACCW-1]) begin
      w_relu = '0;
    end else if (r_acc > RELU_MAX) begin
      w_relu = {{(N-4){1'b0}}, 4'hF};
    end else begin
      w_relu = r_acc[N-1:0];
    end
  end

  // Accumulator and result register; a gated lane holds zero in both.
  always_ff @(posedge i_ck) begin
    if (i_rst) begin
      r_acc  <= '0;
      r_relu <= '0;
    end else begin
      if (i_clr || !i_lane_en) begin
        r_acc <= '0;
      end else if (i_mac) begin
        r_acc <= w_acc_nxt;
      end
      if (i_wr) begin
        r_relu <= i_lane_en ? w_relu : '0;
      end
    end
  end

  assign o_relu = r_relu;
endmodule

// File: rtl/npu_conv_engine.sv
// Convolution engine top: layer-config table, control FSM, address generation and W MAC lanes.
// Build option NPU_CKGATE_EN limits each layer to its configured number of active lanes.
module npu_conv_engine
  import npu_pkg::*;
(
  input  logic             ck,
  input  logic             rst,
  input  logic             start,
  input  logic             c1_c2_n,
  input  logic [N*W-1:0]   i_acth,
  input  logic [N*W-1:0]   i_actv,
  input  logic [1:0]       i_weight,
  output logic [WAW-1:0]   i_weight_addr,
  output logic             i_data_ev_odd_n,
  output logic [AW-1:0]    i_data_even_addr,
  output logic [AW-1:0]    i_data_odd_addr,
  output logic             o_data_ev_odd_n,
  output logic [AW-1:0]    o_data_even_addr,
  output logic [AW-1:0]    o_data_odd_addr,
  output logic             o_data_wr,
  output logic [N*W-1:0]   o_data_relu,
  output logic             ctrl_wr_pipe,
  output logic             done
);
  state_t        r_state;
  layer_cfg_t    r_cfg;
  logic [CW-1:0] r_c, r_t, r_b, r_r, r_s;
  logic          r_out_ev_odd_n;
  logic [AW-1:0] r_out_addr;
  logic          r_data_wr;
  logic          r_wr_pipe;
  logic          r_done;

  logic              w_mac, w_clr, w_wr, w_ldh_v_n;
  logic              w_s_last, w_r_last, w_b_last, w_t_last, w_c_last;
  logic [AW-1:0]     w_data_addr;
  logic [WAW-1:0]    w_wt_addr;
  logic [AW-1:0]     w_idx;
  logic signed [1:0] w_wt;

  assign w_mac     = (r_state == S_MAC);
  assign w_clr     = (r_state == S_CLR);
  assign w_wr      = (r_state == S_WR);
  assign w_ldh_v_n = (r_s == 4'd0);

  assign w_s_last = (r_s == r_cfg.k - 4'd1);
  assign w_r_last = (r_r == r_cfg.k - 4'd1);
  assign w_b_last = (r_b == r_cfg.b - 4'd1);
  assign w_t_last = (r_t == r_cfg.t - 4'd1);
  assign w_c_last = (r_c == r_cfg.c - 4'd1);

  assign w_data_addr = ((AW'(r_b) * AW'(r_cfg.t) + AW'(r_t)) * AW'(r_cfg.k) + AW'(r_r))
                       * AW'(r_cfg.k) + AW'(r_s);
  assign w_wt_addr   = ((WAW'(r_c) * WAW'(r_cfg.b) + WAW'(r_b)) * WAW'(r_cfg.k) + WAW'(r_r))
                       * WAW'(r_cfg.k) + WAW'(r_s);
  assign w_idx       = AW'(r_c) * AW'(r_cfg.t) + AW'(r_t);
  assign w_wt        = w_decode(i_weight);

  // Read-side addresses are only meaningful while taps are being consumed.
  assign i_data_even_addr = w_mac ? w_data_addr : '0;
  assign i_data_odd_addr  = w_mac ? w_data_addr : '0;
  assign i_weight_addr    = w_mac ? w_wt_addr : '0;
  assign i_data_ev_odd_n  = w_mac ? ~r_r[0] : 1'b0;

  assign o_data_ev_odd_n  = r_out_ev_odd_n;
  assign o_data_even_addr = r_out_addr;
  assign o_data_odd_addr  = r_out_addr;
  assign o_data_wr        = r_data_wr;
  assign ctrl_wr_pipe     = r_wr_pipe;
  assign done             = r_done;

  // Control FSM: layer sequencing, tap counters and registered result strobes/address.
  always_ff @(posedge ck) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cfg          <= '0;
      r_c            <= '0;
      r_t            <= '0;
      r_b            <= '0;
      r_r            <= '0;
      r_s            <= '0;
      r_out_ev_odd_n <= 1'b0;
      r_out_addr     <= '0;
      r_data_wr      <= 1'b0;
      r_wr_pipe      <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_data_wr <= 1'b0;
      r_wr_pipe <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cfg   <= cfg_lookup(c1_c2_n);
            r_c     <= '0;
            r_t     <= '0;
            r_state <= S_CLR;
          end
        end
        S_CLR: begin
          r_b     <= '0;
          r_r     <= '0;
          r_s     <= '0;
          r_state <= S_MAC;
        end
        S_MAC: begin
          if (!w_s_last) begin
            r_s <= r_s + 4'd1;
          end else begin
            r_s <= '0;
            if (!w_r_last) begin
              r_r <= r_r + 4'd1;
            end else begin
              r_r <= '0;
              if (!w_b_last) begin
                r_b <= r_b + 4'd1;
              end else begin
                r_b       <= '0;
                r_wr_pipe <= 1'b1;
                r_state   <= S_WR;
              end
            end
          end
        end
        S_WR: begin
          r_data_wr      <= 1'b1;
          r_out_ev_odd_n <= w_idx[0];
          r_out_addr     <= {1'b0, w_idx[AW-1:1]};
          if (!w_t_last) begin
            r_t     <= r_t + 4'd1;
            r_state <= S_CLR;
          end else begin
            r_t <= '0;
            if (!w_c_last) begin
              r_c     <= r_c + 4'd1;
              r_state <= S_CLR;
            end else begin
              r_c     <= '0;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < W; gi++) begin : g_lane
    logic [3:0] w_act;
    logic       w_lane_en;

    assign w_act = w_ldh_v_n ? i_acth[(W-1-gi)*N +: 4] : i_actv[(W-1-gi)*N +: 4];
`ifdef NPU_CKGATE_EN
    assign w_lane_en = (CW'(gi) < r_cfg.ckg);
`else
    assign w_lane_en = 1'b1;
`endif

    npu_mac_lane u_lane (
      .i_ck      (ck),
      .i_rst     (rst),
      .i_clr     (w_clr),
      .i_mac     (w_mac),
      .i_wr      (w_wr),
      .i_lane_en (w_lane_en),
      .i_act     (w_act),
      .i_w       (w_wt),
      .o_relu    (o_data_relu[(W-1-gi)*N +: N])
    );
  end
endmodule

// File: tb/tb_npu_conv_engine.sv
// Self-checking bench for npu_conv_engine: banked activation/weight memories driven from the
// DUT's read addresses, and a loop-nest reference model of each layer's result writes.
module tb_npu_conv_engine;
  import npu_pkg::*;

  logic             ck = 1'b0;
  logic             rst, start, c1_c2_n;
  logic [N*W-1:0]   i_acth, i_actv;
  logic [1:0]       i_weight;
  logic [WAW-1:0]   i_weight_addr;
  logic             i_data_ev_odd_n;
  logic [AW-1:0]    i_data_even_addr, i_data_odd_addr;
  logic             o_data_ev_odd_n;
  logic [AW-1:0]    o_data_even_addr, o_data_odd_addr;
  logic             o_data_wr;
  logic [N*W-1:0]   o_data_relu;
  logic             ctrl_wr_pipe, done;

  int n_chk = 0;
  int n_bad = 0;

  logic [N*W-1:0] ev_mem [0:1023];
  logic [N*W-1:0] od_mem [0:1023];
  logic [1:0]     w_mem  [0:255];

  typedef struct {
    int             idx;
    logic [N*W-1:0] word;
  } wr_t;
  wr_t exp_q[$];

  always #5 ck = ~ck;

  assign i_acth   = i_data_ev_odd_n ? ev_mem[i_data_even_addr] : od_mem[i_data_odd_addr];
  assign i_actv   = i_data_ev_odd_n ? od_mem[i_data_odd_addr] : ev_mem[i_data_even_addr];
  assign i_weight = w_mem[i_weight_addr[7:0]];

  npu_conv_engine dut (
    .ck               (ck),
    .rst              (rst),
    .start            (start),
    .c1_c2_n          (c1_c2_n),
    .i_acth           (i_acth),
    .i_actv           (i_actv),
    .i_weight         (i_weight),
    .i_weight_addr    (i_weight_addr),
    .i_data_ev_odd_n  (i_data_ev_odd_n),
    .i_data_even_addr (i_data_even_addr),
    .i_data_odd_addr  (i_data_odd_addr),
    .o_data_ev_odd_n  (o_data_ev_odd_n),
    .o_data_even_addr (o_data_even_addr),
    .o_data_odd_addr  (o_data_odd_addr),
    .o_data_wr        (o_data_wr),
    .o_data_relu      (o_data_relu),
    .ctrl_wr_pipe     (ctrl_wr_pipe),
    .done             (done)
  );

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // act_v / w_v < 0 selects random values; upper nibble of every lane is always junk.
  task automatic fill(input int act_v, input int w_v);
    for (int a = 0; a < 1024; a++) begin
      for (int l = 0; l < W; l++) begin
        ev_mem[a][l*N +: N] = {4'($urandom_range(15, 0)),
                               (act_v < 0) ? 4'($urandom_range(15, 0)) : 4'(act_v)};
        od_mem[a][l*N +: N] = {4'($urandom_range(15, 0)),
                               (act_v < 0) ? 4'($urandom_range(15, 0)) : 4'(act_v)};
      end
    end
    for (int a = 0; a < 256; a++) begin
      w_mem[a] = (w_v < 0) ? 2'($urandom_range(3, 0)) : 2'(w_v);
    end
  endtask

  function automatic void build_model(input bit c1);
    int k, b_n, c_n, t_n, ckg;
    k   = 3;
    c_n = 4;
    b_n = c1 ? 1 : 4;
    t_n = c1 ? 4 : 2;
`ifdef NPU_CKGATE_EN
    ckg = c1 ? 8 : 6;
`else
    ckg = W;
`endif
    exp_q.delete();
    for (int c = 0; c < c_n; c++) begin
      for (int t = 0; t < t_n; t++) begin
        wr_t e;
        e.idx  = c * t_n + t;
        e.word = '0;
        for (int l = 0; l < W; l++) begin
          int acc, relu;
          acc = 0;
          for (int b = 0; b < b_n; b++) begin
            for (int r = 0; r < k; r++) begin
              for (int s = 0; s < k; s++) begin
                int a, wa, act, wv;
                logic [N*W-1:0] word;
                a  = ((b * t_n + t) * k + r) * k + s;
                wa = ((c * b_n + b) * k + r) * k + s;
                // even rows put the even bank on the horizontal port; s==0 reads horizontal
                word = (((r % 2) == 0) == (s == 0)) ? ev_mem[a] : od_mem[a];
                act  = int'(word[(W-1-l)*N +: 4]);
                wv   = (w_mem[wa] == 2'b01) ? 1 : (w_mem[wa] == 2'b11) ? -1 : 0;
                acc  = acc + wv * act;
                if (acc > 2047) acc = 2047;
                if (acc < -2047) acc = -2047;
              end
            end
          end
          relu = (acc < 0) ? 0 : (acc > 15) ? 15 : acc;
          if (l >= ckg) relu = 0;
          e.word[(W-1-l)*N +: N] = 8'(relu);
        end
        exp_q.push_back(e);
      end
    end
  endfunction

  task automatic run_layer(input string name, input bit c1, input bit poke);
    int  cyc, done_cnt, last_wr, done_cyc, nexp;
    bit  prev_pipe;
    wr_t e;
    build_model(c1);
    nexp     = exp_q.size();
    done_cnt = 0;
    last_wr  = -100;
    done_cyc = -1;
    prev_pipe = 1'b0;
    @(negedge ck);
    c1_c2_n = c1;
    start   = 1'b1;
    @(negedge ck);
    start   = 1'b0;
    c1_c2_n = ~c1;
    cyc = 0;
    while (done_cnt == 0 && cyc < 2000) begin
      start = (poke && cyc == 3) ? 1'b1 : 1'b0;
      @(negedge ck);
      cyc++;
      if (o_data_wr) begin
        chk_eq({name, "_pipe_before_wr"}, 64'(prev_pipe), 64'd1);
        if (exp_q.size() == 0) begin
          chk_eq({name, "_extra_write"}, 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk_eq({name, "_bank"}, 64'(o_data_ev_odd_n), 64'(e.idx % 2));
          chk_eq({name, "_even_addr"}, 64'(o_data_even_addr), 64'(e.idx / 2));
          chk_eq({name, "_odd_addr"}, 64'(o_data_odd_addr), 64'(e.idx / 2));
          chk_eq({name, "_relu"}, 64'(o_data_relu), 64'(e.word));
        end
        last_wr = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_pipe = ctrl_wr_pipe;
    end
    start = 1'b0;
    chk_eq({name, "_done_seen"}, 64'(done_cnt), 64'd1);
    chk_eq({name, "_done_after_last_wr"}, 64'(done_cyc - last_wr), 64'd1);
    chk_eq({name, "_writes_left"}, 64'(exp_q.size()), 64'd0);
    chk_eq({name, "_write_count"}, 64'(nexp), c1 ? 64'd16 : 64'd8);
    @(negedge ck);
    chk_eq({name, "_done_one_cycle"}, 64'(done), 64'd0);
  endtask

  initial begin
    int nwr, nd;
    rst     = 1'b1;
    start   = 1'b0;
    c1_c2_n = 1'b1;
    fill(1, 1);
    repeat (3) @(posedge ck);
    @(negedge ck);
    rst = 1'b0;
    chk_eq("rst_wr", 64'(o_data_wr), 64'd0);
    chk_eq("rst_done", 64'(done), 64'd0);
    chk_eq("rst_pipe", 64'(ctrl_wr_pipe), 64'd0);
    chk_eq("rst_relu", 64'(o_data_relu), 64'd0);
    chk_eq("rst_out_addr", 64'({o_data_even_addr, o_data_odd_addr, o_data_ev_odd_n}), 64'd0);
    chk_eq("rst_in_addr", 64'({i_data_even_addr, i_data_odd_addr, i_data_ev_odd_n}), 64'd0);
    chk_eq("rst_w_addr", 64'(i_weight_addr), 64'd0);

    fill(1, 1);
    run_layer("c1_ones", 1'b1, 1'b0);
    fill(2, 3);
    run_layer("c2_neg", 1'b0, 1'b0);
    fill(15, 1);
    run_layer("c2_clamp", 1'b0, 1'b0);
    fill(1, 1);
    run_layer("c2_ones", 1'b0, 1'b0);
    fill(-1, -1);
    run_layer("c1_poke", 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      fill(-1, -1);
      run_layer("rand", i[0], 1'b0);
    end

    @(negedge ck);
    c1_c2_n = 1'b1;
    start   = 1'b1;
    @(negedge ck);
    start = 1'b0;
    repeat (15) @(negedge ck);
    rst = 1'b1;
    @(negedge ck);
    rst = 1'b0;
    nwr = 0;
    nd  = 0;
    repeat (300) begin
      @(negedge ck);
      if (o_data_wr) nwr++;
      if (done) nd++;
    end
    chk_eq("rst_mid_writes", 64'(nwr), 64'd0);
    chk_eq("rst_mid_done", 64'(nd), 64'd0);

    fill(-1, -1);
    run_layer("after_rst", 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
